// File: rtl/frogger_pkg.sv
// Shared definitions for the frog controller.
//   frog_state_t : controller FSM states
//   dir_t        : hop direction
//   SCREEN_W/SCREEN_H/TILE : playfield geometry in pixels
//   hop_allowed  : true when a one-tile hop in the given direction stays on screen
package frogger_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int TILE     = 40;

    typedef enum logic [2:0] {
        IDLE,
        HOP,
        DEAD,
        HOME,
        OVER
    } frog_state_t;

    typedef enum logic [1:0] {
        UP,
        DOWN,
        LEFT,
        RIGHT
    } dir_t;

    // The frog is one tile wide, so the last legal top-left coordinate is
    // one tile short of the screen edge; a hop needs a whole tile of room.
    function automatic logic hop_allowed(dir_t dir, logic [10:0] x, logic [10:0] y);
        logic ok;
        ok = 1'b0;
        case (dir)
            UP:      ok = (y >= 11'(TILE));
            DOWN:    ok = (y <= 11'(SCREEN_H - 2 * TILE));
            LEFT:    ok = (x >= 11'(TILE));
            RIGHT:   ok = (x <= 11'(SCREEN_W - 2 * TILE));
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/frog_control_if.sv
// Bundle between the frog controller and the rest of the game.
//   Key_Up/Down/Left/Right : key levels from the keyboard decoder
//   Car_Collision_Any      : OR of all car-lane collision flags
//   Frog_X/Frog_Y          : frog top-left position (11 bits)
//   Frog_Side              : frog size in pixels
//   Lives, Home_Count      : game counters
//   Frog_Dead, Frog_Home   : single-frame event pulses
//   Game_Over              : level, high once all lives are spent
// Modports: master = game side (drives keys/collision), slave = frog controller.
interface frog_control_if;

    logic        Key_Up;
    logic        Key_Down;
    logic        Key_Left;
    logic        Key_Right;
    logic        Car_Collision_Any;
    logic [10:0] Frog_X;
    logic [10:0] Frog_Y;
    logic [10:0] Frog_Side;
    logic [1:0]  Lives;
    logic [3:0]  Home_Count;
    logic        Frog_Dead;
    logic        Frog_Home;
    logic        Game_Over;

    modport master (
        output Key_Up, Key_Down, Key_Left, Key_Right, Car_Collision_Any,
        input  Frog_X, Frog_Y, Frog_Side, Lives, Home_Count,
        input  Frog_Dead, Frog_Home, Game_Over
    );

    modport slave (
        input  Key_Up, Key_Down, Key_Left, Key_Right, Car_Collision_Any,
        output Frog_X, Frog_Y, Frog_Side, Lives, Home_Count,
        output Frog_Dead, Frog_Home, Game_Over
    );

endinterface

// File: rtl/key_edge_detect.sv
// Rising-edge detector for key levels, one bit per key.
//   clk   : frame clock
//   rst_n : asynchronous active-low reset
//   key   : key levels
//   press : high for the frame in which a key goes from low to high
// A key must be seen low at least once after reset before it can produce a
// press, so a key already held when reset releases stays silent until it is
// released and pressed again.
module key_edge_detect #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key,
    output logic [N-1:0] press
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_key
            logic prev_reg;
            logic armed_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_reg  <= 1'b0;
                    armed_reg <= 1'b0;
                end else begin
                    prev_reg <= key[gi];
                    if (!key[gi]) begin
                        armed_reg <= 1'b1;
                    end
                end
            end

            assign press[gi] = key[gi] & ~prev_reg & armed_reg;
        end
    endgenerate

endmodule

// File: rtl/frog_control.sv
// Frog movement / life controller, stepped once per video frame.
//   frame_clk : frame clock, all state changes on its rising edge
//   Reset_n   : asynchronous active-low reset
//   bus       : frog_control_if.slave (keys, collision in; position, counters,
//               event pulses out)
// A key press starts a one-tile hop (HOP_FRAMES frames of HOP_STEP pixels),
// a collision freezes the frog for DEATH_FRAMES frames and costs a life,
// reaching the top row counts a crossing and respawns the frog.
// Optional build macro: FROG_INVINCIBLE_EN -- collisions are ignored and
// Lives stays at LIVES_INIT.
module frog_control
    import frogger_pkg::*;
#(
    parameter logic [10:0] START_X      = 11'd300,
    parameter logic [10:0] START_Y      = 11'd440,
    parameter logic [10:0] HOP_STEP     = 11'd10,
    parameter int          HOP_FRAMES   = 4,
    parameter int          DEATH_FRAMES = 30,
    parameter logic [1:0]  LIVES_INIT   = 2'd3
) (
    input  logic           frame_clk,
    input  logic           Reset_n,
    frog_control_if.slave  bus
);

    localparam int HOP_W  = $clog2(HOP_FRAMES + 1);
    localparam int DEAD_W = $clog2(DEATH_FRAMES + 1);

    frog_state_t       state_reg, state_next;
    dir_t              dir_reg, dir_next;
    logic [10:0]       x_reg, x_next;
    logic [10:0]       y_reg, y_next;
    logic [HOP_W-1:0]  hop_cnt_reg, hop_cnt_next;
    logic [DEAD_W-1:0] dead_cnt_reg, dead_cnt_next;
    logic [1:0]        lives_reg, lives_next;
    logic [3:0]        home_cnt_reg, home_cnt_next;

    logic [3:0]        press;
    logic              press_any;
    dir_t              press_dir;
    logic              collision;

    // Bit order: 0 = Up, 1 = Down, 2 = Left, 3 = Right.
    key_edge_detect #(.N(4)) u_key_edge (
        .clk   (frame_clk),
        .rst_n (Reset_n),
        .key   ({bus.Key_Right, bus.Key_Left, bus.Key_Down, bus.Key_Up}),
        .press (press)
    );

`ifdef FROG_INVINCIBLE_EN
    assign collision = 1'b0;
`else
    assign collision = bus.Car_Collision_Any;
`endif

    // Only the highest-priority press is considered; if that hop would leave
    // the screen the whole press is dropped rather than falling through.
    assign press_any = |press;
    always_comb begin
        press_dir = RIGHT;
        if (press[0]) begin
            press_dir = UP;
        end else if (press[1]) begin
            press_dir = DOWN;
        end else if (press[2]) begin
            press_dir = LEFT;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            dir_reg      <= UP;
            x_reg        <= START_X;
            y_reg        <= START_Y;
            hop_cnt_reg  <= '0;
            dead_cnt_reg <= '0;
            lives_reg    <= LIVES_INIT;
            home_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            dir_reg      <= dir_next;
            x_reg        <= x_next;
            y_reg        <= y_next;
            hop_cnt_reg  <= hop_cnt_next;
            dead_cnt_reg <= dead_cnt_next;
            lives_reg    <= lives_next;
            home_cnt_reg <= home_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        dir_next      = dir_reg;
        x_next        = x_reg;
        y_next        = y_reg;
        hop_cnt_next  = hop_cnt_reg;
        dead_cnt_next = dead_cnt_reg;
        lives_next    = lives_reg;
        home_cnt_next = home_cnt_reg;

        unique case (state_reg)
            IDLE: begin
                if (collision) begin
                    state_next    = DEAD;
                    dead_cnt_next = '0;
                    lives_next    = (lives_reg != 2'd0) ? lives_reg - 2'd1 : 2'd0;
                end else if (press_any && hop_allowed(press_dir, x_reg, y_reg)) begin
                    state_next   = HOP;
                    dir_next     = press_dir;
                    hop_cnt_next = '0;
                end
            end

            HOP: begin
                // A collision wins over the move and over hop completion,
                // leaving the frog frozen where it was hit.
                if (collision) begin
                    state_next    = DEAD;
                    dead_cnt_next = '0;
                    lives_next    = (lives_reg != 2'd0) ? lives_reg - 2'd1 : 2'd0;
                end else begin
                    unique case (dir_reg)
                        UP:    y_next = y_reg - HOP_STEP;
                        DOWN:  y_next = y_reg + HOP_STEP;
                        LEFT:  x_next = x_reg - HOP_STEP;
                        RIGHT: x_next = x_reg + HOP_STEP;
                    endcase
                    if (hop_cnt_reg == HOP_W'(HOP_FRAMES - 1)) begin
                        if (y_next == 11'd0) begin
                            state_next    = HOME;
                            home_cnt_next = (home_cnt_reg != 4'd15) ? home_cnt_reg + 4'd1
                                                                    : 4'd15;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        hop_cnt_next = hop_cnt_reg + HOP_W'(1);
                    end
                end
            end

            DEAD: begin
                if (dead_cnt_reg == DEAD_W'(DEATH_FRAMES - 1)) begin
                    if (lives_reg == 2'd0) begin
                        state_next = OVER;
                    end else begin
                        state_next = IDLE;
                        x_next     = START_X;
                        y_next     = START_Y;
                    end
                end else begin
                    dead_cnt_next = dead_cnt_reg + DEAD_W'(1);
                end
            end

            HOME: begin
                state_next = IDLE;
                x_next     = START_X;
                y_next     = START_Y;
            end

            OVER: begin
                state_next = OVER;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.Frog_X     = x_reg;
    assign bus.Frog_Y     = y_reg;
    assign bus.Frog_Side  = 11'(TILE);
    assign bus.Lives      = lives_reg;
    assign bus.Home_Count = home_cnt_reg;
    // The death pulse is the first frame of DEAD; HOME is only one frame long.
    assign bus.Frog_Dead  = (state_reg == DEAD) && (dead_cnt_reg == '0);
    assign bus.Frog_Home  = (state_reg == HOME);
    assign bus.Game_Over  = (state_reg == OVER);

endmodule

// File: tb/tb_frog_control.sv
// Testbench for frog_control: directed scenarios plus randomized key and
// collision traffic, checked against a target-based reference model through
// a scoreboard queue. Honours FROG_INVINCIBLE_EN when defined.
module tb_frog_control;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b0;

    frog_control_if bus ();

    frog_control dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (bus.slave)
    );

    always #5 frame_clk = ~frame_clk;

`ifdef FROG_INVINCIBLE_EN
    localparam bit INVINCIBLE = 1'b1;
`else
    localparam bit INVINCIBLE = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_HOP  = 1;
    localparam int M_DEAD = 2;
    localparam int M_HOME = 3;
    localparam int M_OVER = 4;

    typedef struct {
        int frame;
        int x;
        int y;
        int lives;
        int home;
        bit dead;
        bit homep;
        bit over;
    } exp_t;

    exp_t q[$];

    int n_total = 0;
    int n_pass  = 0;
    int frame_no = 0;

    // Reference model state
    int m_mode, m_x, m_y, m_tx, m_ty, m_lives, m_home, m_dead_left;
    bit m_prev[4];
    bit m_armed[4];

    task automatic check(input string name, input int act, input int expv, input int frame);
        n_total++;
        if (act == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s frame %0d: got %0d expected %0d", name, frame, act, expv);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_x = 300; m_y = 440; m_tx = 300; m_ty = 440;
        m_lives = 3; m_home = 0; m_dead_left = 0;
        for (int i = 0; i < 4; i++) begin
            m_prev[i]  = 1'b0;
            m_armed[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit [3:0] keys, input bit coll_in);
        bit [3:0] pr;
        bit c, dp, hp;
        int dx, dy;
        exp_t e;
        c  = coll_in && !INVINCIBLE;
        dp = 1'b0;
        hp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pr[i] = keys[i] && m_armed[i] && !m_prev[i];
            if (!keys[i]) m_armed[i] = 1'b1;
            m_prev[i] = keys[i];
        end
        if ((m_mode == M_IDLE || m_mode == M_HOP) && c) begin
            m_mode = M_DEAD;
            m_dead_left = 30;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            dp = 1'b1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (pr != 4'b0) begin
                        dx = 0; dy = 0;
                        if (pr[0])      dy = -40;
                        else if (pr[1]) dy = 40;
                        else if (pr[2]) dx = -40;
                        else            dx = 40;
                        if (m_x + dx >= 0 && m_x + dx <= 600 &&
                            m_y + dy >= 0 && m_y + dy <= 440) begin
                            m_tx = m_x + dx;
                            m_ty = m_y + dy;
                            m_mode = M_HOP;
                        end
                    end
                end
                M_HOP: begin
                    if (m_tx > m_x) m_x += 10;
                    if (m_tx < m_x) m_x -= 10;
                    if (m_ty > m_y) m_y += 10;
                    if (m_ty < m_y) m_y -= 10;
                    if (m_x == m_tx && m_y == m_ty) begin
                        if (m_y == 0) begin
                            m_mode = M_HOME;
                            hp = 1'b1;
                            m_home = (m_home < 15) ? m_home + 1 : 15;
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
                M_DEAD: begin
                    m_dead_left--;
                    if (m_dead_left == 0) begin
                        if (m_lives == 0) begin
                            m_mode = M_OVER;
                        end else begin
                            m_mode = M_IDLE;
                            m_x = 300; m_y = 440;
                        end
                    end
                end
                M_HOME: begin
                    m_mode = M_IDLE;
                    m_x = 300; m_y = 440;
                end
                default: ;
            endcase
        end
        frame_no++;
        e.frame = frame_no;
        e.x = m_x; e.y = m_y; e.lives = m_lives; e.home = m_home;
        e.dead = dp; e.homep = hp; e.over = (m_mode == M_OVER);
        q.push_back(e);
    endtask

    // Drive one frame of inputs at the falling edge and queue what the DUT
    // must show after the following rising edge.
    task automatic frame(input bit [3:0] keys, input bit coll);
        @(negedge frame_clk);
        bus.Key_Up            = keys[0];
        bus.Key_Down          = keys[1];
        bus.Key_Left          = keys[2];
        bus.Key_Right         = keys[3];
        bus.Car_Collision_Any = coll;
        model_step(keys, coll);
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) frame(4'b0000, 1'b0);
    endtask

    // Asserts reset between edges once the scoreboard has drained, checks the
    // outputs respond immediately, then releases with the given keys held.
    task automatic do_reset(input bit [3:0] held);
        @(posedge frame_clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_x",     int'(bus.Frog_X),     300, frame_no);
        check("rst_y",     int'(bus.Frog_Y),     440, frame_no);
        check("rst_lives", int'(bus.Lives),      3,   frame_no);
        check("rst_home",  int'(bus.Home_Count), 0,   frame_no);
        check("rst_dead",  int'(bus.Frog_Dead),  0,   frame_no);
        check("rst_homep", int'(bus.Frog_Home),  0,   frame_no);
        check("rst_over",  int'(bus.Game_Over),  0,   frame_no);
        bus.Key_Up            = held[0];
        bus.Key_Down          = held[1];
        bus.Key_Left          = held[2];
        bus.Key_Right         = held[3];
        bus.Car_Collision_Any = 1'b0;
        repeat (2) @(posedge frame_clk);
        #2;
        Reset_n = 1'b1;
        model_reset();
    endtask

    // Monitor: compares each queued expectation just after its rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("frog_x",     int'(bus.Frog_X),     e.x,     e.frame);
                check("frog_y",     int'(bus.Frog_Y),     e.y,     e.frame);
                check("lives",      int'(bus.Lives),      e.lives, e.frame);
                check("home_count", int'(bus.Home_Count), e.home,  e.frame);
                check("frog_dead",  int'(bus.Frog_Dead),  int'(e.dead),  e.frame);
                check("frog_home",  int'(bus.Frog_Home),  int'(e.homep), e.frame);
                check("game_over",  int'(bus.Game_Over),  int'(e.over),  e.frame);
                check("frog_side",  int'(bus.Frog_Side),  40,      e.frame);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Key_Up = 1'b0; bus.Key_Down = 1'b0;
        bus.Key_Left = 1'b0; bus.Key_Right = 1'b0;
        bus.Car_Collision_Any = 1'b0;

        // Up held through reset release: must stay silent until re-pressed.
        do_reset(4'b0001);
        for (int i = 0; i < 5; i++) frame(4'b0001, 1'b0);
        idle_frames(3);
        // Up held 20 frames: exactly one hop to Y=400.
        for (int i = 0; i < 20; i++) frame(4'b0001, 1'b0);
        idle_frames(2);

        // Walk left until the edge, then one more press that must be ignored.
        for (int h = 0; h < 8; h++) begin
            frame(4'b0100, 1'b0);
            idle_frames(5);
        end
        // Up + Right together: upward hop only.
        frame(4'b1001, 1'b0);
        idle_frames(5);

        // Collision on the second frame of a hop.
        frame(4'b0001, 1'b0);
        frame(4'b0000, 1'b0);
        frame(4'b0000, 1'b1);
        idle_frames(35);

        // Eleven upward hops reach the home row.
        for (int h = 0; h < 11; h++) begin
            frame(4'b0001, 1'b0);
            idle_frames(5);
        end
        idle_frames(2);

        // Collisions from IDLE until the game ends, then keys must do nothing.
        for (int k = 0; k < 3; k++) begin
            frame(4'b0000, 1'b1);
            idle_frames(32);
        end
        for (int k = 0; k < 4; k++) begin
            frame(4'b0001, 1'b0);
            frame(4'b0010, 1'b1);
        end
        idle_frames(3);

        // Randomized traffic with periodic mid-game resets.
        for (int blk = 0; blk < 6; blk++) begin
            do_reset(4'($urandom_range(0, 15)));
            for (int f = 0; f < 500; f++) begin
                bit [3:0] keys;
                for (int b = 0; b < 4; b++) keys[b] = ($urandom_range(0, 3) == 0);
                frame(keys, ($urandom_range(0, 79) == 0));
            end
        end

        @(posedge frame_clk);
        #2;
        check("queue_drained", q.size(), 0, frame_no);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
